argmax_top2_pipe: RTL
=====================

// Module: argmax_top2_pipe
// PURPOSE
//  Pipelined classifier decision stage for the CNN output layer: takes one vector of
//  N_CLASSES scores per handshake and returns the winner, the runner-up and the margin between them.
//  Adds signed scores, ready/valid backpressure, top-2 tracking, a tie-break mode and a
//  low-confidence flag to the single-argmax decoder.
//  Sits between the final FC/sum stage and the result/display logic.
// PARAMETERS
//  DATA_WIDTH   16  score width in bits
//  N_CLASSES    10  number of scores per vector; must be >= 2
//  SIGNED       0   1 = scores are two's complement, 0 = unsigned
//  TIE_LOW_IDX  1   1 = the lower index wins equal scores, 0 = the higher index wins
// PORTS
//  clk                clk  in   1                         clock
//  rst_n              in   1                              async reset, active-low
//  in_valid           in   1                              score vector valid
//  in_ready           out  1                              block accepts a vector this cycle
//  in_score           in   DATA_WIDTH x [N_CLASSES]       unpacked score array
//  cfg_margin_thresh  in   DATA_WIDTH                     unsigned; sampled when the output stage loads
//  out_valid          out  1                              result valid
//  out_ready          in   1                              downstream accepts the result
//  out_index          out  IDX_W=$clog2(N_CLASSES)        index of the best score
//  out_best           out  DATA_WIDTH                     best score
//  out_second_index   out  IDX_W                          index of the runner-up
//  out_second         out  DATA_WIDTH                     runner-up score
//  out_margin         out  DATA_WIDTH                     unsigned, out_best - out_second
//  out_low_conf       out  1                              1 when out_margin < cfg_margin_thresh
// BEHAVIOUR
//  - Reset: rst_n is asynchronous, active-low; clock is clk.
//    All pipeline valids and every output reset to 0, including out_valid.
//  - Derived sizes: PADDED = 1<<$clog2(N_CLASSES); STAGES = $clog2(PADDED).
//  - Latency: LAT = STAGES + 2 cycles from input acceptance to out_valid when there is no stall
//    (e.g. 6 for N_CLASSES=10).
//  - Pipeline:
//    - Level 0 registers the inputs.
//    - Each of STAGES merge levels is registered.
//    - The output stage registers margin and low_conf.
//  - Global stall:
//    - en = !out_valid || out_ready.
//    - in_ready = en, combinational.
//    - When en=0 every stage, valid bit and output holds.
//    - Bubbles propagate as invalid stages. No loss, duplication or reordering of vectors.
//  - Handshakes: an input transfers on in_valid && in_ready; an output transfers on out_valid && out_ready.
//  - Padding leaves (index >= N_CLASSES) hold val = MIN and are flagged pad=1:
//    - MIN = -2^(W-1) when SIGNED=1, MIN = 0 otherwise.
//    - A pad leaf never wins or becomes runner-up over a real leaf, including when real scores equal MIN.
//  - Node contents: {best, bidx, second, sidx, bpad, spad}.
//    - A leaf is {s, i, MIN, i, pad, 1}.
//  - Merge of nodes a (lower indices) and b:
//    - a_wins = b.bpad || (!a.bpad && (a.best > b.best || (a.best == b.best && TIE_LOW_IDX))).
//    - Winner w, loser l.
//    - Result best = w.best.
//    - Result second = better of {w.second, l.best}, using the same ordering rule, with pad ranked lowest.
//  - Comparisons are signed or unsigned per SIGNED.
//  - Margin = best - second computed in DATA_WIDTH+1 bits, then truncated to DATA_WIDTH.
//    It is always >= 0 and fits in DATA_WIDTH unsigned bits.
//  - low_conf compares the margin with cfg_margin_thresh, unsigned and strictly less-than.
//  - Reset mid-operation: all in-flight vectors are discarded. The first in_ready after reset release is 1.
//  - Simultaneous output consume and input accept in the same cycle: full throughput, one vector per cycle.
// STRUCTURE
//  - Shared package cnn_cls_pkg:
//    - function min_val(width, signed_mode);
//    - localparams for the TIE_LOW_IDX encodings.
//  - The node struct typedef stays local to the module because it depends on parameters.
//  - Sub-module argmax_top2_node: one registered merge with en, valid in/out and async reset.
//    It is instantiated in a generate tree: level s holds PADDED>>(s+1) nodes.
// TESTING
//  1. N=10, unsigned, scores {5,9,1,3,0,2,8,40,7,6}, out_ready=1
//     -> after 6 cycles: out_index=7, best=40, second_index=1, second=9, margin=31.
//  2. Tie: score[2]=score[5]=50, all others 10, TIE_LOW_IDX=1
//     -> index 2, second_index 5, margin 0; with TIE_LOW_IDX=0 -> index 5, second_index 2.
//  3. SIGNED=1, all scores -100 except score[9]=-3 and score[4]=-7
//     -> index 9, second_index 4, margin 4; no pad index (10..15) is ever reported.
//  4. Five back-to-back vectors; out_ready held low for cycles 7-10
//     -> in_ready low during the stall; results emerge in order, each exactly once.
//  5. best 100, second 95, cfg_margin_thresh=10 -> margin 5, low_conf=1; with thresh=5 -> low_conf=0.
//  6. Assert rst_n low with 3 vectors in flight -> out_valid=0 immediately (async);
//     after release no stale result appears.

Source files
------------

// File: rtl/cnn_cls_pkg.sv
// Shared helpers for the CNN classifier decision stages.
//   min_val()      : most negative representable score for a given width / signedness
//   TIE_MODE_*     : encodings of the TIE_LOW_IDX parameter
package cnn_cls_pkg;

  localparam int TIE_MODE_HIGH = 0;  // higher class index wins equal scores
  localparam int TIE_MODE_LOW  = 1;  // lower class index wins equal scores

  // Bit pattern of the smallest score: 100..0 for two's complement, 0 otherwise.
  // Callers truncate the result to their own width.
  function automatic logic [63:0] min_val(input int width, input bit signed_mode);
    logic [63:0] v;
    v = '0;
    if (signed_mode) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/argmax_top2_pipe_if.sv
// Score-vector in / top-2 result out bus for argmax_top2_pipe.
//   master : producer of scores and consumer of results (upstream/downstream side)
//   slave  : the decision stage itself
//   in_valid/in_ready      input handshake, in_score[N_CLASSES] payload
//   cfg_margin_thresh      low-confidence threshold (unsigned)
//   out_valid/out_ready    output handshake
//   out_index/out_best     winner;  out_second_index/out_second runner-up
//   out_margin             out_best - out_second;  out_low_conf margin < threshold
interface argmax_top2_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CLASSES  = 10
);
  import cnn_cls_pkg::*;

  localparam int IDX_W = $clog2(N_CLASSES);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_score [N_CLASSES];
  logic [DATA_WIDTH-1:0] cfg_margin_thresh;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic [DATA_WIDTH-1:0] out_best;
  logic [IDX_W-1:0]      out_second_index;
  logic [DATA_WIDTH-1:0] out_second;
  logic [DATA_WIDTH-1:0] out_margin;
  logic                  out_low_conf;

  modport master (
    output in_valid, in_score, cfg_margin_thresh, out_ready,
    input  in_ready, out_valid, out_index, out_best, out_second_index,
           out_second, out_margin, out_low_conf
  );

  modport slave (
    input  in_valid, in_score, cfg_margin_thresh, out_ready,
    output in_ready, out_valid, out_index, out_best, out_second_index,
           out_second, out_margin, out_low_conf
  );

endinterface

// File: rtl/argmax_top2_node.sv
// One registered top-2 merge of two subtrees.
//   a_in : node covering the lower class indices,  b_in : the upper ones
//   y    : merged {best, bidx, second, sidx, bpad, spad}, registered when en=1
//   in_vld/out_vld : pipeline valid travelling with the node
// Pad entries rank below every real entry regardless of value, so a real score
// equal to MIN still beats padding.
module argmax_top2_node
  import cnn_cls_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_W       = 4,
  parameter int SIGNED      = 0,
  parameter int TIE_LOW_IDX = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              in_vld,
  input  logic [2*DATA_WIDTH+2*IDX_W+1:0]   a_in,
  input  logic [2*DATA_WIDTH+2*IDX_W+1:0]   b_in,
  output logic                              out_vld,
  output logic [2*DATA_WIDTH+2*IDX_W+1:0]   y
);

  localparam bit TIE_LOW = (TIE_LOW_IDX == TIE_MODE_LOW);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] best;
    logic [IDX_W-1:0]      bidx;
    logic [DATA_WIDTH-1:0] second;
    logic [IDX_W-1:0]      sidx;
    logic                  bpad;
    logic                  spad;
  } node_t;

  function automatic logic gt(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] z);
    if (SIGNED != 0) return $signed(x) > $signed(z);
    return x > z;
  endfunction

  node_t a, b, w, l, m;
  logic  a_wins, x_wins;

  assign a = a_in;
  assign b = b_in;

  always_comb begin
    a_wins = b.bpad || (!a.bpad && (gt(a.best, b.best) || (a.best == b.best && TIE_LOW)));
    w      = a_wins ? a : b;
    l      = a_wins ? b : a;
    // Runner-up: the winner's own runner-up against the loser's best. These can
    // come from either side, so ties are decided by comparing the indices.
    x_wins = l.bpad || (!w.spad && (gt(w.second, l.best) ||
             (w.second == l.best && ((w.sidx < l.bidx) == TIE_LOW))));
    m      = w;
    if (!x_wins) begin
      m.second = l.best;
      m.sidx   = l.bidx;
      m.spad   = l.bpad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      y       <= '0;
    end else if (en) begin
      out_vld <= in_vld;
      y       <= m;
    end
  end

endmodule

// File: rtl/argmax_top2_pipe.sv
// Pipelined top-2 argmax over N_CLASSES scores with ready/valid backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : argmax_top2_pipe_if slave (score vector in, winner/runner-up/margin out)
// Pipeline: input register (leaves), $clog2(PADDED) registered merge levels
// arranged as a heap-indexed tree (node i merges 2i and 2i+1, root is 1), and an
// output register that adds margin and low_conf. One global enable stalls it all.
module argmax_top2_pipe
  import cnn_cls_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int N_CLASSES   = 10,
  parameter int SIGNED      = 0,
  parameter int TIE_LOW_IDX = 1
) (
  input logic               clk,
  input logic               rst_n,
  argmax_top2_pipe_if.slave bus
);

  localparam int IDX_W  = $clog2(N_CLASSES);
  localparam int PADDED = 1 << IDX_W;
  localparam int STAGES = IDX_W;
  localparam int NODE_W = 2*DATA_WIDTH + 2*IDX_W + 2;
  localparam logic [DATA_WIDTH-1:0] MIN = DATA_WIDTH'(min_val(DATA_WIDTH, SIGNED != 0));

  typedef struct packed {
    logic [DATA_WIDTH-1:0] best;
    logic [IDX_W-1:0]      bidx;
    logic [DATA_WIDTH-1:0] second;
    logic [IDX_W-1:0]      sidx;
    logic                  bpad;
    logic                  spad;
  } node_t;

  logic                  en;
  logic                  vld0_q;
  logic [STAGES:0]       vld_pipe;
  logic [DATA_WIDTH-1:0] score_q [N_CLASSES];
  logic [NODE_W-1:0]     tree [1:2*PADDED-1];
  logic [PADDED-1:1]     nvld;

  logic                  out_valid_q;
  logic [IDX_W-1:0]      out_index_q, out_second_index_q;
  logic [DATA_WIDTH-1:0] out_best_q, out_second_q, out_margin_q;
  logic                  out_low_conf_q;

  // Everything advances together; a held output freezes the whole pipe.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // Level 0: input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      for (int j = 0; j < N_CLASSES; j++) score_q[j] <= '0;
    end else if (en) begin
      vld0_q <= bus.in_valid;
      for (int j = 0; j < N_CLASSES; j++) score_q[j] <= bus.in_score[j];
    end
  end

  assign vld_pipe[0] = vld0_q;

  // Leaves: real scores, then constant pad leaves up to the power of two.
  for (genvar j = 0; j < PADDED; j++) begin : g_leaf
    if (j < N_CLASSES) begin : g_real
      assign tree[PADDED+j] = {score_q[j], IDX_W'(j), MIN, IDX_W'(j), 1'b0, 1'b1};
    end else begin : g_pad
      assign tree[PADDED+j] = {MIN, IDX_W'(j), MIN, IDX_W'(j), 1'b1, 1'b1};
    end
  end

  // Merge level s holds heap nodes [NN, 2*NN) with NN = PADDED >> (s+1).
  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int NN = PADDED >> (s + 1);
    for (genvar k = 0; k < NN; k++) begin : g_node
      argmax_top2_node #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .SIGNED     (SIGNED),
        .TIE_LOW_IDX(TIE_LOW_IDX)
      ) u_node (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in_vld (vld_pipe[s]),
        .a_in   (tree[2*(NN+k)]),
        .b_in   (tree[2*(NN+k)+1]),
        .out_vld(nvld[NN+k]),
        .y      (tree[NN+k])
      );
    end
    assign vld_pipe[s+1] = &nvld[2*NN-1:NN];
  end

  // Output stage. The margin is formed one bit wider so a signed best/second pair
  // spanning the full range cannot wrap; the true difference always fits W bits.
  node_t                 root;
  logic [DATA_WIDTH:0]   best_x, second_x;
  logic [DATA_WIDTH-1:0] margin_d;

  assign root     = tree[1];
  assign best_x   = (SIGNED != 0) ? {root.best[DATA_WIDTH-1], root.best}     : {1'b0, root.best};
  assign second_x = (SIGNED != 0) ? {root.second[DATA_WIDTH-1], root.second} : {1'b0, root.second};
  assign margin_d = DATA_WIDTH'(best_x - second_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q        <= 1'b0;
      out_index_q        <= '0;
      out_best_q         <= '0;
      out_second_index_q <= '0;
      out_second_q       <= '0;
      out_margin_q       <= '0;
      out_low_conf_q     <= 1'b0;
    end else if (en) begin
      out_valid_q        <= vld_pipe[STAGES];
      out_index_q        <= root.bidx;
      out_best_q         <= root.best;
      out_second_index_q <= root.sidx;
      out_second_q       <= root.second;
      out_margin_q       <= margin_d;
      out_low_conf_q     <= margin_d < bus.cfg_margin_thresh;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_index        = out_index_q;
  assign bus.out_best         = out_best_q;
  assign bus.out_second_index = out_second_index_q;
  assign bus.out_second       = out_second_q;
  assign bus.out_margin       = out_margin_q;
  assign bus.out_low_conf     = out_low_conf_q;

endmodule
